// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: word size, ALUOp and funct encodings, ALU control codes.
// Definitions common to every configuration; EXEC_OVERFLOW_EN is consumed in execute_stage.
package execute_stage_pkg;

  localparam int WORD = 32;
  localparam int REGADDR_W = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } aluctl_e;

endpackage

// File: rtl/execute_stage_alu_control.sv
// Combinational ALU-control decode: maps ALUOp and the R-type funct field to a 4-bit ALU code.
// Reserved ALUOp and unknown funct values both fall back to ADD.
module alu_control
  import execute_stage_pkg::*;
(
  input  logic [1:0] i_aluOp,
  input  logic [5:0] i_funct,
  output aluctl_e    o_aluCtl
);

  always_comb begin
    o_aluCtl = ALU_ADD;
    case (i_aluOp)
      ALUOP_SUB:   o_aluCtl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_SUB: o_aluCtl = ALU_SUB;
          FUNCT_AND: o_aluCtl = ALU_AND;
          FUNCT_OR:  o_aluCtl = ALU_OR;
          FUNCT_SLT: o_aluCtl = ALU_SLT;
          default:   o_aluCtl = ALU_ADD;
        endcase
      end
      default:     o_aluCtl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: ALU, branch-target adder, destination select and the EX/MEM buffer.
// Optional macro EXEC_OVERFLOW_EN adds the Ovf output and writeback suppression on R-type overflow.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH   = WORD,
  parameter int REGADDR = REGADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [WIDTH-1:0]   nPC,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   SE,
  input  logic [REGADDR-1:0] RT,
  input  logic [REGADDR-1:0] RD,
  input  logic [1:0]         ALUOp,
  input  logic               ALUSrc,
  input  logic               Branch,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               MemtoReg,
  input  logic               RegWrite,
  input  logic               RegDst,
  output logic [WIDTH-1:0]   BTarget,
  output logic               Zero,
  output logic [WIDTH-1:0]   ALUResult,
  output logic [WIDTH-1:0]   WriteData,
  output logic [REGADDR-1:0] WriteReg,
  output logic               Branch_out,
  output logic               MemRead_out,
  output logic               MemWrite_out,
  output logic               MemtoReg_out,
`ifdef EXEC_OVERFLOW_EN
  output logic               Ovf,
`endif
  output logic               RegWrite_out
);

  aluctl_e            w_aluCtl;
  logic [WIDTH-1:0]   w_opB;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_aluResult;
  logic [WIDTH-1:0]   w_bTarget;
  logic [REGADDR-1:0] w_writeReg;
  logic               w_ovf;
  logic               w_regWrite;

  logic [WIDTH-1:0]   r_bTarget;
  logic               r_zero;
  logic [WIDTH-1:0]   r_aluResult;
  logic [WIDTH-1:0]   r_writeData;
  logic [REGADDR-1:0] r_writeReg;
  logic               r_branch;
  logic               r_memRead;
  logic               r_memWrite;
  logic               r_memtoReg;
  logic               r_regWrite;
  logic               r_ovf;

  alu_control u_aluControl (
    .i_aluOp  (ALUOp),
    .i_funct  (SE[5:0]),
    .o_aluCtl (w_aluCtl)
  );

  always_comb begin
    w_opB       = ALUSrc ? SE : B;
    w_sum       = A + w_opB;
    w_diff      = A - w_opB;
    w_bTarget   = nPC + (SE << 2);
    w_writeReg  = RegDst ? RD : RT;
    w_aluResult = w_sum;
    case (w_aluCtl)
      ALU_SUB: w_aluResult = w_diff;
      ALU_AND: w_aluResult = A & w_opB;
      ALU_OR:  w_aluResult = A | w_opB;
      ALU_SLT: w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(w_opB))};
      default: w_aluResult = w_sum;
    endcase
  end

  // Only R-type add/sub can trap; address and branch arithmetic wraps silently.
`ifdef EXEC_OVERFLOW_EN
  always_comb begin
    w_ovf = 1'b0;
    if (ALUOp == ALUOP_RTYPE) begin
      if (w_aluCtl == ALU_ADD)
        w_ovf = (A[WIDTH-1] == w_opB[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      else if (w_aluCtl == ALU_SUB)
        w_ovf = (A[WIDTH-1] != w_opB[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
    end
    w_regWrite = RegWrite & ~w_ovf;
  end
`else
  always_comb begin
    w_ovf      = 1'b0;
    w_regWrite = RegWrite;
  end
`endif

  // EX/MEM buffer: reset and flush both insert an all-zero bubble, stall holds.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_bTarget   <= '0;
      r_zero      <= 1'b0;
      r_aluResult <= '0;
      r_writeData <= '0;
      r_writeReg  <= '0;
      r_branch    <= 1'b0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memtoReg  <= 1'b0;
      r_regWrite  <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (!stall) begin
      r_bTarget   <= w_bTarget;
      r_zero      <= (w_aluResult == '0);
      r_aluResult <= w_aluResult;
      r_writeData <= B;
      r_writeReg  <= w_writeReg;
      r_branch    <= Branch;
      r_memRead   <= MemRead;
      r_memWrite  <= MemWrite;
      r_memtoReg  <= MemtoReg;
      r_regWrite  <= w_regWrite;
      r_ovf       <= w_ovf;
    end
  end

  assign BTarget      = r_bTarget;
  assign Zero         = r_zero;
  assign ALUResult    = r_aluResult;
  assign WriteData    = r_writeData;
  assign WriteReg     = r_writeReg;
  assign Branch_out   = r_branch;
  assign MemRead_out  = r_memRead;
  assign MemWrite_out = r_memWrite;
  assign MemtoReg_out = r_memtoReg;
  assign RegWrite_out = r_regWrite;
`ifdef EXEC_OVERFLOW_EN
  assign Ovf          = r_ovf;
`else
  logic w_unusedOvf;
  assign w_unusedOvf  = r_ovf;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage using a scoreboard of expected EX/MEM contents.
// Honours EXEC_OVERFLOW_EN the same way as the RTL (Ovf port and writeback suppression).
module tb_execute_stage;

  typedef struct packed {
    logic [31:0] bTarget;
    logic        zero;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
    logic        branch;
    logic        memRead;
    logic        memWrite;
    logic        memtoReg;
    logic        regWrite;
    logic        ovf;
  } outT;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] nPC, A, B, SE;
  logic [4:0]  RT, RD;
  logic [1:0]  ALUOp;
  logic        ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, RegDst;
  logic [31:0] BTarget, ALUResult, WriteData;
  logic [4:0]  WriteReg;
  logic        Zero, Branch_out, MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out;
  logic        ovfObs;

  outT sbQ[$];
  outT lastExp;
  outT expV, obsV;
  int  nChecks = 0;
  int  nFail = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .nPC          (nPC),
    .A            (A),
    .B            (B),
    .SE           (SE),
    .RT           (RT),
    .RD           (RD),
    .ALUOp        (ALUOp),
    .ALUSrc       (ALUSrc),
    .Branch       (Branch),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .RegDst       (RegDst),
    .BTarget      (BTarget),
    .Zero         (Zero),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .WriteReg     (WriteReg),
    .Branch_out   (Branch_out),
    .MemRead_out  (MemRead_out),
    .MemWrite_out (MemWrite_out),
    .MemtoReg_out (MemtoReg_out),
`ifdef EXEC_OVERFLOW_EN
    .Ovf          (ovfObs),
`endif
    .RegWrite_out (RegWrite_out)
  );

`ifndef EXEC_OVERFLOW_EN
  assign ovfObs = 1'b0;
`endif

  // Reference model of one EX computation from the currently driven inputs.
  function automatic outT model();
    outT         o;
    logic [31:0] opB, res;
    logic [5:0]  f;
    logic        isAdd, isSub, ov;
    opB   = ALUSrc ? SE : B;
    f     = SE[5:0];
    isAdd = (ALUOp != 2'b01) && !(ALUOp == 2'b10 && (f == 6'b100010 || f == 6'b100100 ||
                                                    f == 6'b100101 || f == 6'b101010));
    isSub = (ALUOp == 2'b01) || (ALUOp == 2'b10 && f == 6'b100010);
    if (isSub)                                 res = A - opB;
    else if (ALUOp == 2'b10 && f == 6'b100100) res = A & opB;
    else if (ALUOp == 2'b10 && f == 6'b100101) res = A | opB;
    else if (ALUOp == 2'b10 && f == 6'b101010) res = {31'd0, $signed(A) < $signed(opB)};
    else                                       res = A + opB;
    ov = 1'b0;
`ifdef EXEC_OVERFLOW_EN
    if (ALUOp == 2'b10 && isAdd) ov = (A[31] == opB[31]) && (res[31] != A[31]);
    if (ALUOp == 2'b10 && isSub) ov = (A[31] != opB[31]) && (res[31] != A[31]);
`endif
    o.bTarget   = nPC + {SE[29:0], 2'b00};
    o.zero      = (res == 32'd0);
    o.aluResult = res;
    o.writeData = B;
    o.writeReg  = RegDst ? RD : RT;
    o.branch    = Branch;
    o.memRead   = MemRead;
    o.memWrite  = MemWrite;
    o.memtoReg  = MemtoReg;
    o.regWrite  = RegWrite & ~ov;
    o.ovf       = ov;
    return o;
  endfunction

  function automatic outT observed();
    outT o;
    o.bTarget   = BTarget;
    o.zero      = Zero;
    o.aluResult = ALUResult;
    o.writeData = WriteData;
    o.writeReg  = WriteReg;
    o.branch    = Branch_out;
    o.memRead   = MemRead_out;
    o.memWrite  = MemWrite_out;
    o.memtoReg  = MemtoReg_out;
    o.regWrite  = RegWrite_out;
    o.ovf       = ovfObs;
    return o;
  endfunction

  // Push what the buffer should hold after the coming edge, then advance past it.
  task automatic applyStimulus();
    outT e;
    if (reset || flush) e = '0;
    else if (stall)     e = lastExp;
    else                e = model();
    lastExp = e;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    reset = 0; stall = 0; flush = 0;
    nPC = 0; A = 0; B = 0; SE = 0; RT = 0; RD = 0; ALUOp = 0;
    ALUSrc = 0; Branch = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0; RegDst = 0;
  endtask

  task automatic randomInputs();
    nPC = $urandom; A = $urandom; B = $urandom; SE = $urandom;
    RT = 5'($urandom); RD = 5'($urandom); ALUOp = 2'($urandom);
    {ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, RegDst} = 7'($urandom);
  endtask

  task automatic test_reset();
    reset = 1;
    randomInputs();
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      expV = sbQ.pop_front(); obsV = observed(); nChecks++;
      if (obsV !== expV) begin
        nFail++; $display("[TB] FAIL reset: got %h expected %h", obsV, expV);
      end
    end
    nChecks++;
    if (obsV !== outT'(0)) begin
      nFail++; $display("[TB] FAIL reset_zero: got %h expected 0", obsV);
    end
    clearInputs();
    A = 5; B = 3; ALUOp = 2'b10; SE = 32'h20; RegDst = 1; RD = 7; RT = 2; RegWrite = 1;
    applyStimulus();
    expV = sbQ.pop_front(); obsV = observed(); nChecks++;
    if (obsV !== expV) begin
      nFail++; $display("[TB] FAIL first_load: got %h expected %h", obsV, expV);
    end
    nChecks++;
    if (ALUResult !== 32'd8 || WriteReg !== 5'd7 || Zero !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL first_load_values: got res=%h reg=%0d zero=%b expected 8/7/0",
               ALUResult, WriteReg, Zero);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] aT[6]  = '{32'hC, 32'hC, 32'hC, 32'hC, 32'hFFFFFFFF, 32'hC};
    logic [31:0] bT[6]  = '{32'hA, 32'hA, 32'hA, 32'hA, 32'h1, 32'hA};
    logic [5:0]  fT[6]  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101010, 6'b111111};
    logic [31:0] rT[6]  = '{32'h2, 32'h8, 32'hE, 32'h0, 32'h1, 32'h16};
    for (int i = 0; i < 6; i++) begin
      clearInputs();
      A = aT[i]; B = bT[i]; SE = {26'd0, fT[i]}; ALUOp = 2'b10; RegWrite = 1; RegDst = 1; RD = 5'(i + 1);
      applyStimulus();
      expV = sbQ.pop_front(); obsV = observed(); nChecks++;
      if (obsV !== expV) begin
        nFail++; $display("[TB] FAIL rtype_%0d: got %h expected %h", i, obsV, expV);
      end
      nChecks++;
      if (ALUResult !== rT[i]) begin
        nFail++; $display("[TB] FAIL rtype_result_%0d: got %h expected %h", i, ALUResult, rT[i]);
      end
    end
  endtask

  task automatic test_branch();
    clearInputs();
    ALUOp = 2'b01; A = 32'h1234; B = 32'h1234; nPC = 32'h100; SE = 32'hFFFFFFFE; Branch = 1;
    applyStimulus();
    expV = sbQ.pop_front(); obsV = observed(); nChecks++;
    if (obsV !== expV) begin
      nFail++; $display("[TB] FAIL branch: got %h expected %h", obsV, expV);
    end
    nChecks++;
    if (Zero !== 1'b1 || BTarget !== 32'hF8 || Branch_out !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL branch_values: got zero=%b bt=%h br=%b expected 1/000000f8/1",
               Zero, BTarget, Branch_out);
    end
  endtask

  task automatic test_loadstore();
    clearInputs();
    ALUOp = 2'b00; ALUSrc = 1; A = 32'h1000; SE = 32'h10; B = 32'hABCD; MemWrite = 1;
    applyStimulus();
    expV = sbQ.pop_front(); obsV = observed(); nChecks++;
    if (obsV !== expV) begin
      nFail++; $display("[TB] FAIL store: got %h expected %h", obsV, expV);
    end
    nChecks++;
    if (ALUResult !== 32'h1010 || WriteData !== 32'hABCD || MemWrite_out !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL store_values: got res=%h wd=%h mw=%b expected 1010/abcd/1",
               ALUResult, WriteData, MemWrite_out);
    end
  endtask

  task automatic test_hazard();
    // load, 3 stalls, flush+stall, fresh load, stall+reset, stall after reset, load
    for (int i = 0; i < 9; i++) begin
      clearInputs();
      randomInputs();
      stall = (i >= 1 && i <= 4) || i == 6 || i == 7;
      flush = (i == 4);
      reset = (i == 6);
      applyStimulus();
      expV = sbQ.pop_front(); obsV = observed(); nChecks++;
      if (obsV !== expV) begin
        nFail++; $display("[TB] FAIL hazard_%0d: got %h expected %h", i, obsV, expV);
      end
    end
  endtask

  task automatic test_overflow();
    clearInputs();
    A = 32'h7FFFFFFF; B = 1; ALUOp = 2'b10; SE = 32'h20; RegWrite = 1;
    applyStimulus();
    expV = sbQ.pop_front(); obsV = observed(); nChecks++;
    if (obsV !== expV) begin
      nFail++; $display("[TB] FAIL ovf_add: got %h expected %h", obsV, expV);
    end
    nChecks++;
`ifdef EXEC_OVERFLOW_EN
    if (ALUResult !== 32'h80000000 || ovfObs !== 1'b1 || RegWrite_out !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL ovf_values: got res=%h ovf=%b rw=%b expected 80000000/1/0",
               ALUResult, ovfObs, RegWrite_out);
    end
`else
    if (ALUResult !== 32'h80000000 || RegWrite_out !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL ovf_values: got res=%h rw=%b expected 80000000/1", ALUResult, RegWrite_out);
    end
`endif
    ALUOp = 2'b00;
    applyStimulus();
    expV = sbQ.pop_front(); obsV = observed(); nChecks++;
    if (obsV !== expV || RegWrite_out !== 1'b1 || ovfObs !== 1'b0) begin
      nFail++; $display("[TB] FAIL ovf_aluop00: got %h expected %h", obsV, expV);
    end
    ALUOp = 2'b10; A = 32'h80000000; B = 1; SE = 32'h22;
    applyStimulus();
    expV = sbQ.pop_front(); obsV = observed(); nChecks++;
    if (obsV !== expV) begin
      nFail++; $display("[TB] FAIL ovf_sub: got %h expected %h", obsV, expV);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fSet[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int i = 0; i < 40; i++) begin
      clearInputs();
      randomInputs();
      if (ALUOp == 2'b10) SE[5:0] = fSet[$urandom_range(0, 5)];
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      applyStimulus();
      expV = sbQ.pop_front(); obsV = observed(); nChecks++;
      if (obsV !== expV) begin
        nFail++; $display("[TB] FAIL b2b_%0d: got %h expected %h", i, obsV, expV);
      end
    end
  endtask

  task automatic checkOutput();
    nChecks++;
    if (sbQ.size() != 0) begin
      nFail++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sbQ.size());
    end
  endtask

  initial begin
    clearInputs();
    lastExp = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_branch();
    test_loadstore();
    test_hazard();
    test_overflow();
    test_back_to_back();
    checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
